// File: rtl/hsc_ddr2_pkg.sv
// Shared types and width defaults for the DDR2 read/write arbiter.
// Imported by the interface, the address generator and the top.
package hsc_ddr2_pkg;

    localparam int ADDR_W_DEF  = 24;
    localparam int DATA_W_DEF  = 32;
    localparam int BURST_W_DEF = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/hsc_ddr2_rw_arbiter_if.sv
// Local-side bus between the arbiter and the DDR2 controller.
// The arbiter is the master; the controller is the slave.
interface hsc_ddr2_rw_arbiter_if
    import hsc_ddr2_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) ();

    logic [ADDR_W-1:0]  local_address;
    logic               local_write_req;
    logic               local_read_req;
    logic               local_burstbegin;
    logic [BURST_W-1:0] local_size;
    logic [DATA_W-1:0]  local_wdata;
    logic               local_ready;
    logic [DATA_W-1:0]  local_rdata;
    logic               local_rdata_valid;

    modport master (
        output local_address,
        output local_write_req,
        output local_read_req,
        output local_burstbegin,
        output local_size,
        output local_wdata,
        input  local_ready,
        input  local_rdata,
        input  local_rdata_valid
    );

    modport slave (
        input  local_address,
        input  local_write_req,
        input  local_read_req,
        input  local_burstbegin,
        input  local_size,
        input  local_wdata,
        output local_ready,
        output local_rdata,
        output local_rdata_valid
    );

endinterface

// File: rtl/hsc_ddr2_addr_gen.sv
// Per-port burst address register: reload, advance and wrap.
// A load seen during this port's own burst is deferred to its end.
module hsc_ddr2_addr_gen #(
    parameter int ADDR_W  = 24,
    parameter int BURST_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  minaddr_i,
    input  logic [ADDR_W-1:0]  maxaddr_i,
    input  logic               load_i,
    input  logic               own_busy_i,
    input  logic               done_i,
    input  logic [BURST_W-1:0] size_i,
    output logic [ADDR_W-1:0]  addr_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [ADDR_W:0]   nxt;
    logic [ADDR_W:0]   nxt_end;
    logic [ADDR_W:0]   lim;
    logic              wrap;

    // Wrap when the next burst would run past maxaddr (inclusive)
    // or when the advance itself carries out of ADDR_W bits.
    always_comb begin
        nxt     = {1'b0, addr_q} + (ADDR_W+1)'(size_i);
        nxt_end = nxt + (ADDR_W+1)'(size_i);
        lim     = {1'b0, maxaddr_i} + (ADDR_W+1)'(1);
        wrap    = nxt[ADDR_W] | (nxt_end > lim);
        addr_d  = addr_q;
        pend_d  = pend_q;
        if (done_i) begin
            pend_d = 1'b0;
            if (pend_q | load_i | wrap) begin
                addr_d = minaddr_i;
            end else begin
                addr_d = nxt[ADDR_W-1:0];
            end
        end else if (load_i) begin
            if (own_busy_i) begin
                pend_d = 1'b1;
            end else begin
                addr_d = minaddr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= minaddr_i;
            pend_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            pend_q <= pend_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/hsc_ddr2_rw_arbiter.sv
// Round-robin write/read burst arbiter in front of a DDR2 controller.
// Writes drain a show-ahead FIFO; reads fill a FIFO from rdata beats.
module hsc_ddr2_rw_arbiter
    import hsc_ddr2_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int BURST_W    = BURST_W_DEF,
    parameter int FIFO_DEPTH = 512,
    parameter int LVL_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               local_init_done,
    input  logic [BURST_W-1:0] wr_rd_burst,
    input  logic [ADDR_W-1:0]  wr_minaddr,
    input  logic [ADDR_W-1:0]  wr_maxaddr,
    input  logic [ADDR_W-1:0]  rd_minaddr,
    input  logic [ADDR_W-1:0]  rd_maxaddr,
    input  logic               wr_load,
    input  logic               rd_load,
    input  logic [LVL_W-1:0]   wr_fifo_level,
    input  logic [DATA_W-1:0]  wr_fifo_q,
    output logic               wr_fifo_rdreq,
    input  logic [LVL_W-1:0]   rd_fifo_level,
    output logic               rd_fifo_wrreq,
    output logic [DATA_W-1:0]  rd_fifo_data,
    hsc_ddr2_rw_arbiter_if.master ctl
);

    state_e             state_q;
    logic               rr_wr_q;
    logic               req_wr_q;
    logic               req_rd_q;
    logic               bb_q;
    logic [BURST_W-1:0] size_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] beat_q;

    logic              wr_elig, rd_elig;
    logic              start, pick_wr, last;
    logic              wr_busy, rd_busy;
    logic              wr_done, rd_done;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    always_comb begin
        wr_elig = 32'(wr_fifo_level) >= 32'(wr_rd_burst);
        rd_elig = (32'(rd_fifo_level) + 32'(wr_rd_burst))
                  <= 32'(FIFO_DEPTH);
        start   = local_init_done && (wr_rd_burst != '0)
                  && (wr_elig || rd_elig);
        pick_wr = wr_elig && (!rd_elig || rr_wr_q);
        last    = beat_q == (size_q - 1'b1);
        wr_busy = state_q == WR_BURST;
        rd_busy = (state_q == RD_CMD) || (state_q == RD_WAIT);
        wr_done = wr_busy && ctl.local_ready && last;
        rd_done = (state_q == RD_WAIT) && ctl.local_rdata_valid
                  && last;
    end

    hsc_ddr2_addr_gen #(
        .ADDR_W  (ADDR_W),
        .BURST_W (BURST_W)
    ) u_wr_addr (
        .clk        (clk),
        .rst        (rst),
        .minaddr_i  (wr_minaddr),
        .maxaddr_i  (wr_maxaddr),
        .load_i     (wr_load),
        .own_busy_i (wr_busy),
        .done_i     (wr_done),
        .size_i     (size_q),
        .addr_o     (wr_addr)
    );

    hsc_ddr2_addr_gen #(
        .ADDR_W  (ADDR_W),
        .BURST_W (BURST_W)
    ) u_rd_addr (
        .clk        (clk),
        .rst        (rst),
        .minaddr_i  (rd_minaddr),
        .maxaddr_i  (rd_maxaddr),
        .load_i     (rd_load),
        .own_busy_i (rd_busy),
        .done_i     (rd_done),
        .size_i     (size_q),
        .addr_o     (rd_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_wr_q  <= 1'b1;
            req_wr_q <= 1'b0;
            req_rd_q <= 1'b0;
            bb_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    beat_q <= '0;
                    if (start) begin
                        size_q <= wr_rd_burst;
                        bb_q   <= 1'b1;
                        if (pick_wr) begin
                            state_q  <= WR_BURST;
                            req_wr_q <= 1'b1;
                            addr_q   <= wr_addr;
                            rr_wr_q  <= 1'b0;
                        end else begin
                            state_q  <= RD_CMD;
                            req_rd_q <= 1'b1;
                            addr_q   <= rd_addr;
                            rr_wr_q  <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (ctl.local_ready) begin
                        bb_q   <= 1'b0;
                        beat_q <= beat_q + 1'b1;
                        if (last) begin
                            state_q  <= IDLE;
                            req_wr_q <= 1'b0;
                        end
                    end
                end
                RD_CMD: begin
                    if (ctl.local_ready) begin
                        req_rd_q <= 1'b0;
                        bb_q     <= 1'b0;
                        beat_q   <= '0;
                        state_q  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (ctl.local_rdata_valid) begin
                        beat_q <= beat_q + 1'b1;
                        if (last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctl.local_address    = addr_q;
    assign ctl.local_write_req  = req_wr_q;
    assign ctl.local_read_req   = req_rd_q;
    assign ctl.local_burstbegin = bb_q;
    assign ctl.local_size       = size_q;
    assign ctl.local_wdata      = wr_fifo_q;

    assign wr_fifo_rdreq = req_wr_q & ctl.local_ready;
    assign rd_fifo_wrreq = (state_q == RD_WAIT) & ctl.local_rdata_valid;
    assign rd_fifo_data  = ctl.local_rdata;

endmodule

// File: tb/tb_hsc_ddr2_rw_arbiter.sv
// Self-checking bench for hsc_ddr2_rw_arbiter: eligibility table,
// command scoreboard and hand-written multi-cycle sequences.
module tb_hsc_ddr2_rw_arbiter;
    import hsc_ddr2_pkg::*;

    localparam logic [31:0] WBASE = 32'hA000_0000;
    localparam logic [31:0] RBASE = 32'hB000_0000;
    localparam logic [31:0] MDATA = 32'hDEAD_BEEF;

    typedef struct {
        logic        wr;
        logic [23:0] addr;
    } exp_t;

    typedef struct {
        logic       init;
        logic [6:0] burst;
        logic [9:0] wl;
        logic [9:0] rl;
        int         exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic [6:0]  burst = 7'd16;
    logic [23:0] wr_min = 24'h0;
    logic [23:0] wr_max = 24'd63;
    logic [23:0] rd_min = 24'h100;
    logic [23:0] rd_max = 24'h13F;
    logic        wr_load = 1'b0;
    logic        rd_load = 1'b0;
    logic [9:0]  wr_lvl = '0;
    logic [9:0]  rd_lvl = '0;
    logic [31:0] wr_q;
    logic        wr_rdreq;
    logic        rd_wrreq;
    logic [31:0] rd_data;
    logic        ready = 1'b1;
    logic        auto_valid = 1'b0;
    logic        man_valid = 1'b0;
    logic [31:0] auto_data = '0;
    logic        rsp_hold = 1'b0;
    logic        bb_prev = 1'b0;
    logic        sb_en = 1'b0;

    int pop_cnt = 0;
    int push_cnt = 0;
    int cmd_cnt = 0;
    int bb_rise = 0;
    int rd_pending = 0;
    int rsp_cnt = 0;
    int n_chk = 0;
    int n_fail = 0;

    exp_t exp_q[$];
    vec_t vt[9];

    hsc_ddr2_rw_arbiter_if #(
        .ADDR_W  (24),
        .DATA_W  (32),
        .BURST_W (7)
    ) bus ();

    hsc_ddr2_rw_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .local_init_done (init_done),
        .wr_rd_burst     (burst),
        .wr_minaddr      (wr_min),
        .wr_maxaddr      (wr_max),
        .rd_minaddr      (rd_min),
        .rd_maxaddr      (rd_max),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .wr_fifo_level   (wr_lvl),
        .wr_fifo_q       (wr_q),
        .wr_fifo_rdreq   (wr_rdreq),
        .rd_fifo_level   (rd_lvl),
        .rd_fifo_wrreq   (rd_wrreq),
        .rd_fifo_data    (rd_data),
        .ctl             (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.local_ready       = ready;
    assign bus.local_rdata_valid = auto_valid | man_valid;
    assign bus.local_rdata       = man_valid ? MDATA : auto_data;
    assign wr_q                  = WBASE + 32'(pop_cnt);

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Write FIFO model: show-ahead word advances on each pop.
    always @(posedge clk) begin
        if (wr_rdreq) pop_cnt <= pop_cnt + 1;
    end

    // Controller read-return model.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            rd_pending = 0;
            auto_valid = 1'b0;
        end else if (!rsp_hold && rd_pending > 0) begin
            auto_valid = 1'b1;
            auto_data  = RBASE + 32'(rsp_cnt);
            rsp_cnt++;
            rd_pending--;
        end else begin
            auto_valid = 1'b0;
        end
    end

    // Mid-cycle monitor and command scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.local_burstbegin && !bb_prev) bb_rise++;
        bb_prev = bus.local_burstbegin;
        if (wr_rdreq) begin
            check("wdata", bus.local_wdata, WBASE + 32'(pop_cnt));
        end
        if (rd_wrreq) begin
            check("rd_push_data", rd_data, RBASE + 32'(push_cnt));
            push_cnt++;
        end
        if (bus.local_burstbegin && ready && !rst) begin
            cmd_cnt++;
            if (bus.local_read_req) begin
                rd_pending += int'(bus.local_size);
            end
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL cmd_unexpected: got addr %0h, required none",
                             bus.local_address);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_type", bus.local_write_req, e.wr);
                    check("cmd_addr", bus.local_address, e.addr);
                    check("cmd_size", bus.local_size, burst);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        init_done = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_exp(input logic wr, input logic [23:0] a);
        exp_t e;
        e.wr   = wr;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic wait_cmds(input int target, input string nm);
        int k = 0;
        while (cmd_cnt < target && k < 600) begin
            tick();
            k++;
        end
        check(nm, 64'(cmd_cnt >= target), 64'd1);
    endtask

    task automatic wait_pops(input int target, input string nm);
        int k = 0;
        while (pop_cnt != target && k < 600) begin
            tick();
            k++;
        end
        check(nm, 64'(pop_cnt == target), 64'd1);
    endtask

    task automatic wait_idle(input string nm);
        int  k = 0;
        logic ok = 1'b0;
        while (!ok && k < 600) begin
            tick();
            k++;
            ok = (dut.state_q == IDLE) && (rd_pending == 0)
                 && !auto_valid;
        end
        check(nm, 64'(ok), 64'd1);
    endtask

    initial begin
        int p0, q0, c0, b0, got;

        vt[0] = '{1'b0, 7'd16,  10'd64,  10'd0,   0};
        vt[1] = '{1'b1, 7'd0,   10'd64,  10'd0,   0};
        vt[2] = '{1'b1, 7'd16,  10'd15,  10'd500, 0};
        vt[3] = '{1'b1, 7'd16,  10'd16,  10'd500, 1};
        vt[4] = '{1'b1, 7'd16,  10'd0,   10'd496, 2};
        vt[5] = '{1'b1, 7'd16,  10'd64,  10'd0,   1};
        vt[6] = '{1'b1, 7'd16,  10'd0,   10'd497, 0};
        vt[7] = '{1'b1, 7'd1,   10'd1,   10'd511, 1};
        vt[8] = '{1'b1, 7'd127, 10'd126, 10'd385, 2};

        // Reset state with eligible stimulus held.
        rst = 1'b1;
        init_done = 1'b1;
        wr_lvl = 10'd64;
        tick();
        tick();
        tick();
        sample();
        check("rst_wr_req", bus.local_write_req, 0);
        check("rst_rd_req", bus.local_read_req, 0);
        check("rst_bb", bus.local_burstbegin, 0);
        check("rst_size", bus.local_size, 0);
        check("rst_addr", bus.local_address, 0);
        check("rst_rdreq", wr_rdreq, 0);
        check("rst_wrreq", rd_wrreq, 0);
        check("rst_state", dut.state_q, IDLE);
        check("rst_wr_ptr", dut.u_wr_addr.addr_o, wr_min);
        check("rst_rd_ptr", dut.u_rd_addr.addr_o, rd_min);

        // Eligibility / priority table.
        for (int i = 0; i < 9; i++) begin
            tick();
            rst = 1'b1;
            init_done = vt[i].init;
            burst = vt[i].burst;
            wr_lvl = vt[i].wl;
            rd_lvl = vt[i].rl;
            tick();
            tick();
            rst = 1'b0;
            got = 0;
            for (int k = 0; k < 4 && got == 0; k++) begin
                tick();
                sample();
                if (bus.local_write_req) got = 1;
                else if (bus.local_read_req) got = 2;
            end
            check($sformatf("table_%0d", i), 64'(got), 64'(vt[i].exp));
        end
        tick();
        burst = 7'd16;
        reset_dut();
        sb_en = 1'b1;

        // Write-only address walk with wrap.
        wr_lvl = 10'd64;
        rd_lvl = 10'd512;
        p0 = pop_cnt;
        c0 = cmd_cnt;
        push_exp(1, 0);
        push_exp(1, 16);
        push_exp(1, 32);
        push_exp(1, 48);
        push_exp(1, 0);
        init_done = 1'b1;
        wait_cmds(c0 + 5, "walk_cmds");
        init_done = 1'b0;
        wait_idle("walk_idle");
        check("walk_pops", 64'(pop_cnt - p0), 64'd80);
        check("walk_sb_empty", 64'(exp_q.size()), 0);

        // Both eligible: alternate W,R,W,R.
        reset_dut();
        wr_lvl = 10'd64;
        rd_lvl = 10'd0;
        p0 = pop_cnt;
        q0 = push_cnt;
        c0 = cmd_cnt;
        b0 = bb_rise;
        push_exp(1, 24'h0);
        push_exp(0, 24'h100);
        push_exp(1, 24'h10);
        push_exp(0, 24'h110);
        init_done = 1'b1;
        wait_cmds(c0 + 4, "rr_cmds");
        init_done = 1'b0;
        wait_idle("rr_idle");
        check("rr_pops", 64'(pop_cnt - p0), 64'd32);
        check("rr_pushes", 64'(push_cnt - q0), 64'd32);
        check("rr_bb_rises", 64'(bb_rise - b0), 64'd4);
        check("rr_sb_empty", 64'(exp_q.size()), 0);

        // Back-pressure on the first beat and on beat 5.
        reset_dut();
        wr_lvl = 10'd64;
        rd_lvl = 10'd512;
        ready = 1'b0;
        p0 = pop_cnt;
        push_exp(1, 0);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("bp_bb_held", bus.local_burstbegin, 1);
            check("bp_first_wdata", bus.local_wdata, WBASE + 32'(p0));
            tick();
        end
        ready = 1'b1;
        wait_pops(p0 + 4, "bp_reach_beat5");
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("bp5_no_pop", wr_rdreq, 0);
            check("bp5_wdata", bus.local_wdata, WBASE + 32'(p0 + 4));
            check("bp5_bb_low", bus.local_burstbegin, 0);
            tick();
        end
        ready = 1'b1;
        wait_idle("bp_idle");
        check("bp_pops", 64'(pop_cnt - p0), 64'd16);
        check("bp_sb_empty", 64'(exp_q.size()), 0);

        // Load during own burst at address 32 is deferred.
        reset_dut();
        wr_lvl = 10'd64;
        rd_lvl = 10'd512;
        p0 = pop_cnt;
        c0 = cmd_cnt;
        push_exp(1, 0);
        push_exp(1, 16);
        push_exp(1, 32);
        push_exp(1, 0);
        init_done = 1'b1;
        wait_pops(p0 + 40, "ld_reach_beat8");
        wr_load = 1'b1;
        tick();
        wr_load = 1'b0;
        wait_cmds(c0 + 4, "ld_cmds");
        init_done = 1'b0;
        wait_idle("ld_idle");
        check("ld_pops", 64'(pop_cnt - p0), 64'd64);
        check("ld_sb_empty", 64'(exp_q.size()), 0);

        // Read on exactly-enough FIFO space.
        reset_dut();
        wr_lvl = 10'd0;
        rd_lvl = 10'd496;
        q0 = push_cnt;
        c0 = cmd_cnt;
        push_exp(0, 24'h100);
        init_done = 1'b1;
        wait_cmds(c0 + 1, "rd_cmds");
        init_done = 1'b0;
        wait_idle("rd_idle");
        check("rd_pushes", 64'(push_cnt - q0), 64'd16);

        // Reset in RD_WAIT, then stray rdata_valid.
        reset_dut();
        rd_lvl = 10'd0;
        rsp_hold = 1'b1;
        q0 = push_cnt;
        c0 = cmd_cnt;
        push_exp(0, 24'h100);
        init_done = 1'b1;
        wait_cmds(c0 + 1, "rw_cmds");
        init_done = 1'b0;
        tick();
        sample();
        check("rw_in_wait", dut.state_q, RD_WAIT);
        tick();
        rst = 1'b1;
        tick();
        man_valid = 1'b1;
        sample();
        check("rw_state", dut.state_q, IDLE);
        check("rw_wr_req", bus.local_write_req, 0);
        check("rw_rd_req", bus.local_read_req, 0);
        check("rw_bb", bus.local_burstbegin, 0);
        check("rw_size", bus.local_size, 0);
        check("rw_addr", bus.local_address, 0);
        check("rw_push_rst", rd_wrreq, 0);
        tick();
        rst = 1'b0;
        sample();
        check("rw_push_stray", rd_wrreq, 0);
        tick();
        man_valid = 1'b0;
        rsp_hold = 1'b0;
        tick();
        check("rw_pushes", 64'(push_cnt - q0), 64'd0);
        check("rw_sb_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
